seq_subtractor: RTL and testbench
=================================

# seq_subtractor

Parametrised multi-cycle subtractor computing `a - b - bin` over `WIDTH` bits, `DIGIT` bits per clock, LSB digit first. Each cycle applies a `DIGIT`-wide full-subtractor slice and registers the borrow into the next digit. The block sits in the arithmetic datapath wherever area matters more than latency. It uses a start/busy/done handshake, so a controlling FSM can issue operations back to back.

## Interface
- `WIDTH`, 16, operand and result width in bits; must be ≥ 1.
- `DIGIT`, 4, bits processed per cycle; must be ≥ 1 and divide `WIDTH`. `NDIG = WIDTH/DIGIT`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; sampled with accepted `start`.
- `b`  in  WIDTH  subtrahend; sampled with accepted `start`.
- `bin`  in  1  borrow-in; sampled with accepted `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; result valid.
- `diff`  out  WIDTH  result; held until the next result is written.
- `bout`  out  1  borrow out of the MSB; high when `a < b + bin` (unsigned).
- `ovf`  out  1  signed overflow. Present only with `SEQ_SUB_OVF_EN`.

## Operation
- States are IDLE, RUN and DONE.
- IDLE → RUN on an edge with `start=1`:
  - latch `a`, `b` and `bin` into working registers;
  - clear the digit counter;
  - set the running borrow to `bin`.
- RUN, on each edge:
  - process digit `i`: `{br', d} = a[i] - b[i] - br`;
  - write `d` into result bits `[i*DIGIT +: DIGIT]`;
  - set `br ← br'`;
  - increment the counter.
- RUN → DONE on the edge that processes digit `NDIG-1`. On that same edge, `diff` and `bout` (and `ovf`) are loaded from the working result and final borrow.
- DONE → IDLE unconditionally on the next edge.
- `start` in RUN or DONE is ignored, with no queuing. Operand changes while busy have no effect.
- `diff`, `bout` and `ovf` change only on the RUN→DONE edge or on reset. They are stable through DONE and the following IDLE period.
- Arithmetic is unsigned modulo 2^WIDTH. `diff = (a - b - bin) mod 2^WIDTH`. `bout` = 1 iff `a < b + bin`, with the comparison done in WIDTH+1 bits.
- `WIDTH == DIGIT` (`NDIG = 1`) is legal: RUN lasts exactly one cycle.
- Reset asserted at any time, including mid-RUN:
  - state returns to IDLE immediately;
  - the working registers and counter are cleared;
  - the partial result is discarded.
- Reset values: `busy=0`, `done=0`, `diff=0`, `bout=0`, `ovf=0`.

## Timing
- Edge E0 accepts `start`.
- `busy` is high for cycles E0..E(NDIG), i.e. exactly `NDIG` cycles.
- `done` is high for the single cycle after edge E(NDIG). `diff` and `bout` are valid from that same edge.
- The earliest next accepted `start` is at edge E(NDIG+2), because the DONE cycle is not accepting. Throughput is one operation per `NDIG+2` cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The digit counter is `$clog2(NDIG)+1` bits wide, so it does not wrap before the terminal compare.

## Configuration
- Macro: `SEQ_SUB_OVF_EN`.
- Defined:
  - the `ovf` port exists;
  - `ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1])`, using the latched operands;
  - `ovf` is registered alongside `diff` and holds with it.
- Undefined: no `ovf` port and no associated logic.
- All other behaviour is identical with and without the macro.

## Test plan
- WIDTH=16, DIGIT=4, `a=0x1234`, `b=0x0234`, `bin=0`:
  - `diff=0x1000`, `bout=0`;
  - `busy` high for 4 cycles;
  - `done` pulses once, 4 edges after the start edge.
- `a=0x0000`, `b=0x0001`, `bin=0` → `diff=0xFFFF`, `bout=1`. Also `a=0x0005`, `b=0x0005`, `bin=1` → `diff=0xFFFF`, `bout=1`.
- `start` held high continuously with changing operands:
  - only operations accepted in IDLE execute, with one accepted every 6 cycles;
  - results match the operands sampled at each accepted edge.
- `rst_n` pulsed low during the 2nd RUN cycle:
  - all outputs go to 0 immediately;
  - no `done` follows;
  - a subsequent op `0x00FF - 0x0001` gives `0x00FE`.
- With `SEQ_SUB_OVF_EN`:
  - `0x8000 - 0x0001` → `diff=0x7FFF`, `ovf=1`, `bout=0`;
  - `0x7FFF - 0xFFFF` → `diff=0x8000`, `ovf=1`, `bout=1`.
- WIDTH=4, DIGIT=1, all 512 combinations of `a`/`b`/`bin` compared against the model `{bout,diff} = a - b - bin` in 5 bits. Repeat with WIDTH=4, DIGIT=4.

Source files
------------

// File: rtl/seq_subtractor_if.sv
// seq_subtractor_if: start/busy/done handshake and operand/result bus for
// seq_subtractor. The ovf signal exists only when SEQ_SUB_OVF_EN is defined.
interface seq_subtractor_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SEQ_SUB_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout
`ifdef SEQ_SUB_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout
`ifdef SEQ_SUB_OVF_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/seq_subtractor.sv
// seq_subtractor: digit-serial a - b - bin over WIDTH bits, DIGIT bits per
// clock, LSB digit first, with a start/busy/done handshake.
// Optional feature macro: SEQ_SUB_OVF_EN adds a registered signed-overflow flag.
module seq_subtractor #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   seq_subtractor_if.slave  bus
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = $clog2(NDIG) + 1;
   localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             br_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;
   logic             busy_q;
   logic             done_q;

   logic [31:0]      base;
   logic [DIGIT:0]   slice;
   logic [WIDTH-1:0] res_next;
   logic             last_dig;
`ifdef SEQ_SUB_OVF_EN
   logic             ovf_q;
   logic             ovf_next;
`endif

   // Full-subtractor slice for the current digit; the extra top bit is the borrow out.
   always_comb begin
      base      = 32'(cnt_q) * 32'(DIGIT);
      slice     = {1'b0, a_q[base +: DIGIT]} - {1'b0, b_q[base +: DIGIT]}
                  - {{DIGIT{1'b0}}, br_q};
      res_next  = res_q;
      res_next[base +: DIGIT] = slice[DIGIT-1:0];
      last_dig  = (cnt_q == LAST_DIG);
`ifdef SEQ_SUB_OVF_EN
      ovf_next  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_next[WIDTH-1] != a_q[WIDTH-1]);
`endif
   end

   // Control FSM plus working and result registers; results load only on the final digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SEQ_SUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  br_q    <= bus.bin;
                  cnt_q   <= '0;
                  res_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               res_q <= res_next;
               br_q  <= slice[DIGIT];
               cnt_q <= cnt_q + CW'(1);
               if (last_dig) begin
                  diff_q  <= res_next;
                  bout_q  <= slice[DIGIT];
`ifdef SEQ_SUB_OVF_EN
                  ovf_q   <= ovf_next;
`endif
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
`ifdef SEQ_SUB_OVF_EN
   assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_subtractor.sv
// tb_seq_subtractor: directed bench for seq_subtractor at 16/4, 4/1 and 4/4.
// Overflow checks are compiled in when SEQ_SUB_OVF_EN is defined.
module tb_seq_subtractor;
   logic clk = 1'b0;
   logic rst_n;
   int   ncmp  = 0;
   int   nfail = 0;

   always #5 clk = ~clk;

   seq_subtractor_if #(.WIDTH(16)) bus16 ();
   seq_subtractor_if #(.WIDTH(4))  bus41 ();
   seq_subtractor_if #(.WIDTH(4))  bus44 ();

   seq_subtractor #(.WIDTH(16), .DIGIT(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
   seq_subtractor #(.WIDTH(4),  .DIGIT(1)) u_dut41 (.clk(clk), .rst_n(rst_n), .bus(bus41));
   seq_subtractor #(.WIDTH(4),  .DIGIT(4)) u_dut44 (.clk(clk), .rst_n(rst_n), .bus(bus44));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One 16-bit operation: busy for 4 cycles, done pulse after E4, then result held.
   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       input logic [15:0] ediff, input logic ebout, input logic eovf,
                       input string tag);
      @(negedge clk);
      bus16.start = 1'b1;
      bus16.a     = a;
      bus16.b     = b;
      bus16.bin   = bin;
      @(posedge clk);
      #1 bus16.start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk({tag, "_busy"}, 32'({bus16.busy, bus16.done}), 32'h2);
      end
      @(negedge clk);
      chk({tag, "_done"}, 32'({bus16.busy, bus16.done}), 32'h1);
      chk({tag, "_diff"}, 32'(bus16.diff), 32'(ediff));
      chk({tag, "_bout"}, 32'(bus16.bout), 32'(ebout));
`ifdef SEQ_SUB_OVF_EN
      chk({tag, "_ovf"}, 32'(bus16.ovf), 32'(eovf));
`else
      if (eovf === 1'bx) $display("note: eovf unknown for %s", tag);
`endif
      @(negedge clk);
      chk({tag, "_pulse"}, 32'({bus16.busy, bus16.done}), 32'h0);
      chk({tag, "_hold"}, 32'({bus16.bout, bus16.diff}), 32'({ebout, ediff}));
   endtask

   initial begin
      logic [15:0] ha [0:17];
      logic [15:0] hb [0:17];
      logic        hbin [0:17];
      logic [16:0] m17;
      logic [8:0]  v;
      logic [4:0]  m5;

      bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.bin = 1'b0;
      bus41.start = 1'b0; bus41.a = '0; bus41.b = '0; bus41.bin = 1'b0;
      bus44.start = 1'b0; bus44.a = '0; bus44.b = '0; bus44.bin = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst16", 32'({bus16.busy, bus16.done, bus16.bout, bus16.diff}), 32'h0);
      chk("rst41", 32'({bus41.busy, bus41.done, bus41.bout, bus41.diff}), 32'h0);
`ifdef SEQ_SUB_OVF_EN
      chk("rst_ovf", 32'(bus16.ovf), 32'h0);
`endif
      rst_n = 1'b1;

      op16(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, "basic");
      op16(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, "under");
      op16(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, "binwrap");
      op16(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, "ovf_neg");
      op16(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, "ovf_pos");

      // start held high with operands changing every cycle
      for (int n = 0; n < 18; n++) begin
         ha[n]   = 16'h3000 + 16'(n) * 16'h0101;
         hb[n]   = 16'h0100 + 16'(n) * 16'h0011;
         hbin[n] = n[0];
      end
      @(negedge clk);
      bus16.start = 1'b1;
      bus16.a = ha[0]; bus16.b = hb[0]; bus16.bin = hbin[0];
      for (int n = 0; n < 18; n++) begin
         @(posedge clk);
         @(negedge clk);
         chk("held_hs", 32'({bus16.busy, bus16.done}),
             32'({((n % 6) < 4), ((n % 6) == 4)}));
         if ((n % 6) == 4) begin
            m17 = {1'b0, ha[n-4]} - {1'b0, hb[n-4]} - 17'(hbin[n-4]);
            chk("held_res", 32'({bus16.bout, bus16.diff}), 32'(m17));
         end
         if (n < 17) begin
            bus16.a = ha[n+1]; bus16.b = hb[n+1]; bus16.bin = hbin[n+1];
         end
      end
      bus16.start = 1'b0;

      // reset asserted in the second RUN cycle
      @(negedge clk);
      bus16.start = 1'b1; bus16.a = 16'h1234; bus16.b = 16'h0234; bus16.bin = 1'b0;
      @(posedge clk);
      #1 bus16.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst", 32'({bus16.busy, bus16.done, bus16.bout, bus16.diff}), 32'h0);
`ifdef SEQ_SUB_OVF_EN
      chk("midrst_ovf", 32'(bus16.ovf), 32'h0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("nodone", 32'({bus16.busy, bus16.done}), 32'h0);
      end
      op16(16'h00FF, 16'h0001, 1'b0, 16'h00FE, 1'b0, 1'b0, "postrst");

      // exhaustive 4-bit sweep, one bit per cycle
      for (int i = 0; i < 512; i++) begin
         v = 9'(i);
         @(negedge clk);
         bus41.start = 1'b1; bus41.a = v[8:5]; bus41.b = v[4:1]; bus41.bin = v[0];
         @(posedge clk);
         #1 bus41.start = 1'b0;
         repeat (4) @(negedge clk);
         @(negedge clk);
         m5 = {1'b0, v[8:5]} - {1'b0, v[4:1]} - 5'(v[0]);
         chk("w4d1", 32'({bus41.done, bus41.bout, bus41.diff}), 32'({1'b1, m5}));
      end

      // exhaustive 4-bit sweep, single-digit operation
      for (int i = 0; i < 512; i++) begin
         v = 9'(i);
         @(negedge clk);
         bus44.start = 1'b1; bus44.a = v[8:5]; bus44.b = v[4:1]; bus44.bin = v[0];
         @(posedge clk);
         #1 bus44.start = 1'b0;
         @(negedge clk);
         chk("w4d4_busy", 32'({bus44.busy, bus44.done}), 32'h2);
         @(negedge clk);
         m5 = {1'b0, v[8:5]} - {1'b0, v[4:1]} - 5'(v[0]);
         chk("w4d4", 32'({bus44.done, bus44.bout, bus44.diff}), 32'({1'b1, m5}));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
